// File: rtl/column_ram_sweep_checker_if.sv
// Column RAM access bus between the sweep checker (master) and the RAM (slave).
interface column_ram_sweep_checker_if #(
  parameter int QUAN_SIZE         = 4,
  parameter int CHECK_PARALLELISM = 85,
  parameter int ADDR              = 10
);
  logic [QUAN_SIZE-1:0]                   ram_din;
  logic [ADDR-1:0]                        ram_addr;
  logic                                   ram_we;
  logic [CHECK_PARALLELISM*QUAN_SIZE-1:0] ram_dout;

  modport master (output ram_din, output ram_addr, output ram_we, input ram_dout);
  modport slave  (input ram_din, input ram_addr, input ram_we, output ram_dout);
endinterface

// File: rtl/column_ram_sweep_checker.sv
// Write/read-back sweep checker for the column message RAM.
// Optional first-failure capture (fail_addr/fail_lane) under FIRST_FAIL_CAPTURE_EN.
//
// state   | meaning
// IDLE    | waiting for start
// WRITE   | a pattern write is on the bus this cycle
// READ    | a read is on the bus this cycle
// DRAIN   | reads issued, waiting for the last data to be compared
// DONE    | one-cycle result report
module column_ram_sweep_checker #(
  parameter int QUAN_SIZE         = 4,
  parameter int CHECK_PARALLELISM = 85,
  parameter int DEPTH             = 1024,
  parameter int ADDR              = $clog2(DEPTH),
  parameter int RD_LAT            = 2
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR-1:0]      addr_base,
  input  logic [ADDR:0]        addr_len,
  input  logic [QUAN_SIZE-1:0] seed,
  column_ram_sweep_checker_if.master ram,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR:0]        err_cnt
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic [ADDR-1:0]      fail_addr,
  output logic [6:0]           fail_lane
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t               state;
  logic [ADDR-1:0]      base_q;
  logic [ADDR:0]        len_q;
  logic [QUAN_SIZE-1:0] seed_q;
  logic [ADDR:0]        rem;
  logic [ADDR-1:0]      addr_r;
  logic [QUAN_SIZE-1:0] din_r;
  logic                 we_r;

  logic [RD_LAT-1:0]    pipe_vld;
  logic [QUAN_SIZE-1:0] pipe_exp [RD_LAT];
`ifdef FIRST_FAIL_CAPTURE_EN
  logic [ADDR-1:0]      pipe_addr [RD_LAT];
  logic [6:0]           first_lane;
`endif

  logic                 any_bad;
  logic                 cmp_fail;
  logic                 drain_busy;
  logic [ADDR:0]        err_nxt;

  assign ram.ram_addr = addr_r;
  assign ram.ram_din  = din_r;
  assign ram.ram_we   = we_r;

  function automatic logic [ADDR-1:0] wrap_inc(input logic [ADDR-1:0] a);
    return (a == ADDR'(DEPTH-1)) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [QUAN_SIZE-1:0] pattern(input logic [QUAN_SIZE-1:0] s,
                                                   input logic [ADDR-1:0] a);
    return s + a[QUAN_SIZE-1:0];
  endfunction

  // Lane compare against the expected word leaving the read pipeline
  always_comb begin
    any_bad = 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
    first_lane = '0;
`endif
    for (int k = CHECK_PARALLELISM-1; k >= 0; k--) begin
      if (ram.ram_dout[k*QUAN_SIZE +: QUAN_SIZE] != pipe_exp[RD_LAT-1]) begin
        any_bad = 1'b1;
`ifdef FIRST_FAIL_CAPTURE_EN
        first_lane = 7'(k);
`endif
      end
    end
  end

  assign cmp_fail = pipe_vld[RD_LAT-1] && any_bad &&
                    (state == S_READ || state == S_DRAIN);
  assign err_nxt  = (cmp_fail && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;

  // Anything still in flight after the current edge keeps DRAIN waiting
  always_comb begin
    drain_busy = 1'b0;
    for (int j = 0; j < RD_LAT-1; j++) drain_busy = drain_busy | pipe_vld[j];
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      seed_q   <= '0;
      rem      <= '0;
      addr_r   <= '0;
      din_r    <= '0;
      we_r     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      pipe_vld <= '0;
      for (int j = 0; j < RD_LAT; j++) pipe_exp[j] <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
      for (int j = 0; j < RD_LAT; j++) pipe_addr[j] <= '0;
      fail_addr <= '0;
      fail_lane <= '0;
`endif
    end else begin
      pipe_vld[0] <= (state == S_READ);
      pipe_exp[0] <= din_r;
      for (int j = 1; j < RD_LAT; j++) begin
        pipe_vld[j] <= pipe_vld[j-1];
        pipe_exp[j] <= pipe_exp[j-1];
      end
`ifdef FIRST_FAIL_CAPTURE_EN
      pipe_addr[0] <= addr_r;
      for (int j = 1; j < RD_LAT; j++) pipe_addr[j] <= pipe_addr[j-1];
      if (cmp_fail && err_cnt == '0) begin
        fail_addr <= pipe_addr[RD_LAT-1];
        fail_lane <= first_lane;
      end
`endif
      if (state == S_READ || state == S_DRAIN) err_cnt <= err_nxt;

      case (state)
        S_IDLE: begin
          if (start) begin
            base_q  <= addr_base;
            len_q   <= addr_len;
            seed_q  <= seed;
            err_cnt <= '0;
            busy    <= 1'b1;
`ifdef FIRST_FAIL_CAPTURE_EN
            fail_addr <= '0;
            fail_lane <= '0;
`endif
            if (addr_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state  <= S_WRITE;
              pass   <= 1'b0;
              we_r   <= 1'b1;
              addr_r <= addr_base;
              din_r  <= pattern(seed, addr_base);
              rem    <= addr_len - 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (rem == '0) begin
            state  <= S_READ;
            we_r   <= 1'b0;
            addr_r <= base_q;
            din_r  <= pattern(seed_q, base_q);
            rem    <= len_q - 1'b1;
          end else begin
            addr_r <= wrap_inc(addr_r);
            din_r  <= pattern(seed_q, wrap_inc(addr_r));
            rem    <= rem - 1'b1;
          end
        end
        S_READ: begin
          if (rem == '0) begin
            state <= S_DRAIN;
          end else begin
            addr_r <= wrap_inc(addr_r);
            din_r  <= pattern(seed_q, wrap_inc(addr_r));
            rem    <= rem - 1'b1;
          end
        end
        S_DRAIN: begin
          if (!drain_busy) begin
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_column_ram_sweep_checker.sv
// Directed bench for column_ram_sweep_checker with a 2-cycle-latency RAM model
// that can inject lane faults.
module tb_column_ram_sweep_checker;
  localparam int Q = 4;
  localparam int P = 85;
  localparam int A = 10;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [A-1:0]  addr_base = '0;
  logic [A:0]    addr_len = '0;
  logic [Q-1:0]  seed = '0;
  logic          busy, done, pass;
  logic [A:0]    err_cnt;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic [A-1:0]  fail_addr;
  logic [6:0]    fail_lane;
`endif

  int checks = 0;
  int failures = 0;

  column_ram_sweep_checker_if #(.QUAN_SIZE(Q), .CHECK_PARALLELISM(P), .ADDR(A)) bus ();

  column_ram_sweep_checker #(.QUAN_SIZE(Q), .CHECK_PARALLELISM(P), .DEPTH(1024), .RD_LAT(2)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .start     (start),
    .addr_base (addr_base),
    .addr_len  (addr_len),
    .seed      (seed),
    .ram       (bus),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt)
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    .fail_addr (fail_addr),
    .fail_lane (fail_lane)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // RAM model: broadcast write, two-register read path, optional faults
  logic [Q-1:0]   mem [1024];
  logic [P*Q-1:0] d1 = '0, d2 = '0;
  int             fault_mode = 0;

  function automatic logic [P*Q-1:0] lanes_at(input logic [A-1:0] a);
    logic [P*Q-1:0] v;
    logic [Q-1:0]   w;
    v = '0;
    for (int k = 0; k < P; k++) begin
      w = mem[a];
      if (fault_mode == 1 && a == 10'd5 && k == 40) w = '0;
      if (fault_mode == 2) w = ~w;
      v[k*Q +: Q] = w;
    end
    return v;
  endfunction

  always @(posedge sys_clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    d1 <= lanes_at(bus.ram_addr);
    d2 <= d1;
  end
  assign bus.ram_dout = d2;

  // Observations from the last sweep
  int           done_cyc;
  int           we_cnt;
  logic         busy_k1;
  logic [A-1:0] wr_addr_q[$];
  logic [Q-1:0] wr_din_q[$];
  logic [A-1:0] rd_addr_q[$];

  task automatic run_sweep(input logic [A-1:0] b, input logic [A:0] l, input logic [Q-1:0] s,
                           input int inject_k, input int budget);
    wr_addr_q.delete(); wr_din_q.delete(); rd_addr_q.delete();
    we_cnt = 0; done_cyc = -1; busy_k1 = 1'b0;
    @(negedge sys_clk);
    addr_base = b; addr_len = l; seed = s; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      if (k > 1) @(negedge sys_clk);
      if (k == inject_k) begin
        addr_base = 10'd500; addr_len = 11'd3; seed = 4'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (k == 1) busy_k1 = busy;
      if (bus.ram_we) begin
        we_cnt++;
        wr_addr_q.push_back(bus.ram_addr);
        wr_din_q.push_back(bus.ram_din);
      end
      if (k > int'(l) && k <= 2*int'(l)) rd_addr_q.push_back(bus.ram_addr);
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", bus.ram_we); end
    checks++; if (bus.ram_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0d want=0", bus.ram_addr); end
    checks++; if (bus.ram_din !== '0) begin failures++; $display("FAIL reset_din got=%0d want=0", bus.ram_din); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b want=0", pass); end
    checks++; if (err_cnt !== '0) begin failures++; $display("FAIL reset_err got=%0d want=0", err_cnt); end
`ifdef FIRST_FAIL_CAPTURE_EN
    checks++; if (fail_addr !== '0) begin failures++; $display("FAIL reset_fail_addr got=%0d want=0", fail_addr); end
    checks++; if (fail_lane !== '0) begin failures++; $display("FAIL reset_fail_lane got=%0d want=0", fail_lane); end
`endif
    rst = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_basic();
    logic [Q-1:0] exp_din [16] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10,
                                    4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
    fault_mode = 0;
    run_sweep(10'd0, 11'd16, 4'd3, 0, 200);
    checks++; if (done_cyc != 35) begin failures++; $display("FAIL basic_done_cycle got=%0d want=35", done_cyc); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL basic_pass got=%b want=1", pass); end
    checks++; if (err_cnt !== 11'd0) begin failures++; $display("FAIL basic_err got=%0d want=0", err_cnt); end
    checks++; if (we_cnt != 16) begin failures++; $display("FAIL basic_we_count got=%0d want=16", we_cnt); end
    checks++; if (rd_addr_q.size() != 16) begin failures++; $display("FAIL basic_rd_count got=%0d want=16", rd_addr_q.size()); end
    for (int i = 0; i < 16 && i < wr_addr_q.size() && i < rd_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== 10'(i)) begin failures++; $display("FAIL basic_wr_addr[%0d] got=%0d want=%0d", i, wr_addr_q[i], i); end
      checks++; if (wr_din_q[i] !== exp_din[i]) begin failures++; $display("FAIL basic_wr_din[%0d] got=%0d want=%0d", i, wr_din_q[i], exp_din[i]); end
      checks++; if (rd_addr_q[i] !== 10'(i)) begin failures++; $display("FAIL basic_rd_addr[%0d] got=%0d want=%0d", i, rd_addr_q[i], i); end
    end
    @(negedge sys_clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b want=0", busy); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL basic_pass_hold got=%b want=1", pass); end
  endtask

  task automatic test_stuck_lane();
    fault_mode = 1;
    run_sweep(10'd0, 11'd8, 4'd0, 0, 200);
    checks++; if (done_cyc != 19) begin failures++; $display("FAIL stuck_done_cycle got=%0d want=19", done_cyc); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL stuck_pass got=%b want=0", pass); end
    checks++; if (err_cnt !== 11'd1) begin failures++; $display("FAIL stuck_err got=%0d want=1", err_cnt); end
`ifdef FIRST_FAIL_CAPTURE_EN
    checks++; if (fail_addr !== 10'd5) begin failures++; $display("FAIL stuck_fail_addr got=%0d want=5", fail_addr); end
    checks++; if (fail_lane !== 7'd40) begin failures++; $display("FAIL stuck_fail_lane got=%0d want=40", fail_lane); end
`endif
    fault_mode = 0;
  endtask

  task automatic test_wrap();
    logic [A-1:0] exp_addr [4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    logic [Q-1:0] exp_din  [4] = '{4'd5, 4'd6, 4'd7, 4'd8};
    run_sweep(10'd1022, 11'd4, 4'd7, 0, 200);
    checks++; if (done_cyc != 11) begin failures++; $display("FAIL wrap_done_cycle got=%0d want=11", done_cyc); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL wrap_pass got=%b want=1", pass); end
    checks++; if (we_cnt != 4) begin failures++; $display("FAIL wrap_we_count got=%0d want=4", we_cnt); end
    for (int i = 0; i < 4 && i < wr_addr_q.size() && i < rd_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== exp_addr[i]) begin failures++; $display("FAIL wrap_wr_addr[%0d] got=%0d want=%0d", i, wr_addr_q[i], exp_addr[i]); end
      checks++; if (wr_din_q[i] !== exp_din[i]) begin failures++; $display("FAIL wrap_wr_din[%0d] got=%0d want=%0d", i, wr_din_q[i], exp_din[i]); end
      checks++; if (rd_addr_q[i] !== exp_addr[i]) begin failures++; $display("FAIL wrap_rd_addr[%0d] got=%0d want=%0d", i, rd_addr_q[i], exp_addr[i]); end
    end
  endtask

  task automatic test_len_zero();
    run_sweep(10'd0, 11'd0, 4'd5, 0, 10);
    checks++; if (done_cyc != 1) begin failures++; $display("FAIL zero_done_cycle got=%0d want=1", done_cyc); end
    checks++; if (we_cnt != 0) begin failures++; $display("FAIL zero_we_count got=%0d want=0", we_cnt); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL zero_pass got=%b want=1", pass); end
    checks++; if (busy_k1 !== 1'b1) begin failures++; $display("FAIL zero_busy got=%b want=1", busy_k1); end
    checks++; if (err_cnt !== 11'd0) begin failures++; $display("FAIL zero_err got=%0d want=0", err_cnt); end
  endtask

  task automatic test_start_during_read();
    int busy_seen;
    run_sweep(10'd100, 11'd8, 4'd2, 11, 200);
    checks++; if (done_cyc != 19) begin failures++; $display("FAIL ignore_done_cycle got=%0d want=19", done_cyc); end
    checks++; if (we_cnt != 8) begin failures++; $display("FAIL ignore_we_count got=%0d want=8", we_cnt); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL ignore_pass got=%b want=1", pass); end
    busy_seen = 0;
    repeat (6) begin
      @(negedge sys_clk);
      if (busy) busy_seen++;
    end
    checks++; if (busy_seen != 0) begin failures++; $display("FAIL ignore_busy_after got=%0d want=0", busy_seen); end
  endtask

  task automatic test_reset_in_write();
    int done_seen, busy_seen;
    @(negedge sys_clk);
    addr_base = 10'd0; addr_len = 11'd16; seed = 4'd1; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("FAIL rstmid_we got=%b want=0", bus.ram_we); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    rst = 1'b0;
    done_seen = 0; busy_seen = 0;
    repeat (40) begin
      @(negedge sys_clk);
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d want=0", done_seen); end
    checks++; if (busy_seen != 0) begin failures++; $display("FAIL rstmid_no_busy got=%0d want=0", busy_seen); end
    run_sweep(10'd0, 11'd8, 4'd9, 0, 200);
    checks++; if (done_cyc != 19) begin failures++; $display("FAIL rstmid_clean_done got=%0d want=19", done_cyc); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL rstmid_clean_pass got=%b want=1", pass); end
    checks++; if (err_cnt !== 11'd0) begin failures++; $display("FAIL rstmid_clean_err got=%0d want=0", err_cnt); end
  endtask

  task automatic test_all_lanes();
    fault_mode = 2;
    run_sweep(10'd0, 11'd1024, 4'd5, 0, 3000);
    checks++; if (done_cyc != 2051) begin failures++; $display("FAIL all_done_cycle got=%0d want=2051", done_cyc); end
    checks++; if (we_cnt != 1024) begin failures++; $display("FAIL all_we_count got=%0d want=1024", we_cnt); end
    checks++; if (err_cnt !== 11'd1024) begin failures++; $display("FAIL all_err got=%0d want=1024", err_cnt); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL all_pass got=%b want=0", pass); end
`ifdef FIRST_FAIL_CAPTURE_EN
    checks++; if (fail_addr !== 10'd0) begin failures++; $display("FAIL all_fail_addr got=%0d want=0", fail_addr); end
    checks++; if (fail_lane !== 7'd0) begin failures++; $display("FAIL all_fail_lane got=%0d want=0", fail_lane); end
`endif
    fault_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuck_lane();
    test_wrap();
    test_len_zero();
    test_start_during_read();
    test_reset_in_write();
    test_all_lanes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/column_ram_sweep_checker.md
# column_ram_sweep_checker

Sequencing controller for the column RAM (`column_ram_pc85`) in the layer decoder memory subsystem. It writes a deterministic 4-bit message pattern across a programmable address window. It then reads the window back and checks all 85 lane outputs against the expected pattern. It reports pass/fail, a count of failing addresses and, optionally, the first failure location, for bring-up and built-in self-test of the message memory.

## Interface
- `QUAN_SIZE`, 4: message width in bits.
- `CHECK_PARALLELISM`, 85: number of lanes read back per address.
- `DEPTH`, 1024: RAM depth.
- `ADDR`, $clog2(DEPTH): address width.
- `RD_LAT`, 2: cycles from the read address being presented to `ram_dout` being valid. Range is 1 to 4.

Ports:
- `sys_clk` input, 1 bit: the single clock. Everything is on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: one-cycle request. Sampled only in IDLE.
- `addr_base` input, ADDR bits: first address of the window. Sampled with `start`.
- `addr_len` input, ADDR+1 bits: number of addresses in the window, 0 to DEPTH. Sampled with `start`.
- `seed` input, QUAN_SIZE bits: pattern seed. Sampled with `start`.
- `ram_din` output, QUAN_SIZE bits: write data broadcast to all lanes.
- `ram_addr` output, ADDR bits: the RAM `sync_addr`.
- `ram_we` output, 1 bit: RAM write enable.
- `ram_dout` input, CHECK_PARALLELISM×QUAN_SIZE bits: flattened lane outputs. Lane k occupies bits [k*QUAN_SIZE +: QUAN_SIZE].
- `busy` output, 1 bit: high from the cycle after `start` is accepted until DONE.
- `done` output, 1 bit: one-cycle pulse at the end of a sweep.
- `pass` output, 1 bit: result of the last sweep. Valid while `done` is high and holds until the next accepted `start`.
- `err_cnt` output, ADDR+1 bits: number of failing addresses. Saturates at all-ones.
- `fail_addr` output, ADDR bits: first failing address. Only with `FIRST_FAIL_CAPTURE_EN`.
- `fail_lane` output, 7 bits: lowest failing lane index at `fail_addr`. Only with `FIRST_FAIL_CAPTURE_EN`.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: waits for `start`.
  - `start`=1 latches `addr_base`, `addr_len` and `seed`, and clears `err_cnt` and `pass`.
  - With `addr_len`≠0 the next state is WRITE.
  - With `addr_len`=0 the next state is DONE directly and `pass`=1.
- WRITE: issues one write per cycle for i = 0 .. L−1.
  - `ram_addr` = (`addr_base`+i) mod DEPTH, so the window wraps past DEPTH−1 to 0.
  - `ram_we`=1.
  - `ram_din` = (`seed` + addr[QUAN_SIZE-1:0]) mod 2^QUAN_SIZE, where addr is the wrapped address.
  - After i = L−1 the next state is READ.
- READ: issues one read per cycle over the same address sequence, with `ram_we`=0.
  - A valid bit and the expected pattern enter an RD_LAT-deep shift pipeline together.
  - After the last issue the next state is DRAIN.
- DRAIN: waits until the pipeline is empty, then goes to DONE.
- Compare stage (active in READ and DRAIN):
  - Runs whenever the pipeline output is valid.
  - An address fails if any lane of `ram_dout` differs from the expected pattern.
  - Each failing address increments `err_cnt` by 1, saturating at all-ones.
- DONE: lasts one cycle.
  - `done`=1.
  - `pass` = (`err_cnt`==0).
  - Next state is IDLE.
- `start` while not in IDLE is ignored.
- `ram_we` is 0 in every state except WRITE.
- `ram_addr` and `ram_din` hold their last value outside WRITE and READ.
- Reset in the middle of a sweep:
  - Return to IDLE.
  - `ram_we` is deasserted in the same cycle the reset is sampled.
  - The pipeline is flushed.
  - Nothing from the interrupted sweep is reported.

## Timing
- Reset values: `ram_we`=0, `ram_addr`=0, `ram_din`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_addr`=0, `fail_lane`=0.
- All outputs are registered.
- Let `start` be sampled at edge T, with window length L≥1:
  - writes are driven in cycles T+1 .. T+L;
  - reads are issued in cycles T+L+1 .. T+2L;
  - the last compare happens at T+2L+RD_LAT;
  - `done` is high in cycle T+2L+RD_LAT+1.
- With L=0, `done` is high in cycle T+1.
- `busy` is high from T+1 through the `done` cycle inclusive.
- A new `start` is accepted in the cycle after `done`.
- Throughput is one RAM access per cycle with no bubbles between the write phase and the read phase.

## Configuration
- `FIRST_FAIL_CAPTURE_EN` defined:
  - `fail_addr` and `fail_lane` exist.
  - On the first failing compare of a sweep, they capture that address and the lowest mismatching lane index.
  - They hold until the next accepted `start`, which clears them to 0.
- Not defined: these ports and their capture logic are absent. All other behaviour is identical.

## Test plan
- Fault-free RAM model, RD_LAT=2, base=0, len=16, seed=3 -> `ram_din` reads 3,4,..,15,0,1,2 at addresses 0..15; `done` is high at T+35; `pass`=1; `err_cnt`=0.
- Model with lane 40 stuck at 0 at address 5, base=0, len=8, seed=0 -> `pass`=0, `err_cnt`=1; with the macro, `fail_addr`=5 and `fail_lane`=40.
- base=1022, len=4 -> addresses 1022,1023,0,1 are used in both phases; `pass`=1.
- len=0 -> no `ram_we` pulse; `done` and `pass`=1 at T+1.
- `start` pulsed during READ is ignored. Separately, `rst` asserted in WRITE: `ram_we`=0 on the next cycle, no `done`, and the next `start` runs a clean sweep.
- All 85 lanes corrupted at every address, len=1024 -> `err_cnt`=1024, no saturation wrap; `pass`=0.
